// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core LSU (port 0)
// and the debug/DMA loader (port 1), with alignment checking and a bounded port-1 bus lock.
module dmem_arbiter #(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [BIT_WIDTH-1:0]  wdata0,
    input  logic [BIT_WIDTH-1:0]  wdata1,
    input  logic                  byte0,
    input  logic                  half0,
    input  logic                  byte1,
    input  logic                  half1,
    input  logic                  zext0,
    input  logic                  zext1,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [BIT_WIDTH-1:0]  rdata0,
    output logic [BIT_WIDTH-1:0]  rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic [ADDR_WIDTH-1:0] mem_readAddr,
    output logic [ADDR_WIDTH-1:0] mem_writeAddr,
    output logic [BIT_WIDTH-1:0]  mem_writeData,
    output logic                  mem_writeEn,
    output logic                  mem_addr_byte,
    output logic                  mem_addr_half,
    output logic                  mem_zero_extend,
    input  logic [BIT_WIDTH-1:0]  mem_readData
);

    typedef enum logic [1:0] {UNLOCKED, LOCKED, COOLDOWN} lock_state_e;

    localparam logic [8:0] LOCK_LIMIT = 9'(LOCK_MAX);

    lock_state_e          state_q;
    logic [7:0]           lock_cnt_q;
    logic [8:0]           lock_cnt_d;
    logic                 last_owner_q;
    logic                 rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [BIT_WIDTH-1:0] rdata0_q, rdata1_q, rdata0_d, rdata1_d;
    logic                 byte0_w, half0_w, byte1_w, half1_w;
    logic                 mis0, mis1;
    logic [ADDR_WIDTH-1:0] mem_addr;

    function automatic logic misaligned(input logic [1:0] a, input logic is_byte, input logic is_half);
        if (is_byte)
            return 1'b0;
        if (is_half)
            return a[0];
        return a != 2'b00;
    endfunction

    // Both size bits high is illegal and collapses to a word access.
    assign byte0_w = byte0 & ~half0;
    assign half0_w = half0 & ~byte0;
    assign byte1_w = byte1 & ~half1;
    assign half1_w = half1 & ~byte1;
    assign mis0    = misaligned(addr0[1:0], byte0_w, half0_w);
    assign mis1    = misaligned(addr1[1:0], byte1_w, half1_w);

    assign gnt1 = rst_n & req1 & (state_q != COOLDOWN)
                & ((state_q == LOCKED) | ~req0 | ~last_owner_q);
    assign gnt0 = rst_n & req0 & ~gnt1;

    always_comb begin
        mem_addr        = '0;
        mem_writeData   = '0;
        mem_writeEn     = 1'b0;
        mem_addr_byte   = 1'b0;
        mem_addr_half   = 1'b0;
        mem_zero_extend = 1'b0;
        if (gnt0) begin
            mem_addr        = addr0;
            mem_writeData   = wdata0;
            mem_writeEn     = we0 & ~mis0;
            mem_addr_byte   = byte0_w;
            mem_addr_half   = half0_w;
            mem_zero_extend = zext0;
        end else if (gnt1) begin
            mem_addr        = addr1;
            mem_writeData   = wdata1;
            mem_writeEn     = we1 & ~mis1;
            mem_addr_byte   = byte1_w;
            mem_addr_half   = half1_w;
            mem_zero_extend = zext1;
        end
    end

    assign mem_readAddr  = mem_addr;
    assign mem_writeAddr = mem_addr;

    assign rdata0_d   = (we0 | mis0) ? '0 : mem_readData;
    assign rdata1_d   = (we1 | mis1) ? '0 : mem_readData;
    assign lock_cnt_d = {1'b0, lock_cnt_q} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
            err0_q    <= gnt0 & mis0;
            err1_q    <= gnt1 & mis1;
            if (gnt0)
                rdata0_q <= rdata0_d;
            if (gnt1)
                rdata1_q <= rdata1_d;
        end
    end

    // Lock FSM and round-robin history; a locked grant still counts as a port-1 win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= UNLOCKED;
            lock_cnt_q   <= 8'd0;
            last_owner_q <= 1'b1;
        end else begin
            if (gnt1)
                last_owner_q <= 1'b1;
            else if (gnt0)
                last_owner_q <= 1'b0;
            case (state_q)
                UNLOCKED: begin
                    if (gnt1 && lock1) begin
                        lock_cnt_q <= 8'd1;
                        state_q    <= (LOCK_MAX <= 1) ? COOLDOWN : LOCKED;
                    end
                end
                LOCKED: begin
                    if (gnt1 && lock1 && (lock_cnt_d < LOCK_LIMIT)) begin
                        lock_cnt_q <= lock_cnt_d[7:0];
                    end else begin
                        lock_cnt_q <= 8'd0;
                        state_q    <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    lock_cnt_q <= 8'd0;
                    state_q    <= UNLOCKED;
                end
                default: state_q <= UNLOCKED;
            endcase
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle accesses, then hand-written
// lock and reset sequences. A small byte memory stands in for the data memory.
module tb_dmem_arbiter;

    localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10, BH = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, byte0, half0, byte1, half1, zext0, zext1, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_readAddr, mem_writeAddr, mem_writeData, mem_readData;
    logic        mem_writeEn, mem_addr_byte, mem_addr_half, mem_zero_extend;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.BIT_WIDTH(32), .ADDR_WIDTH(32), .LOCK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .byte0(byte0), .half0(half0), .byte1(byte1), .half1(half1),
        .zext0(zext0), .zext1(zext1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_readAddr(mem_readAddr), .mem_writeAddr(mem_writeAddr),
        .mem_writeData(mem_writeData), .mem_writeEn(mem_writeEn),
        .mem_addr_byte(mem_addr_byte), .mem_addr_half(mem_addr_half),
        .mem_zero_extend(mem_zero_extend), .mem_readData(mem_readData)
    );

    // Little-endian byte memory with combinational, size-aware read and extension.
    logic [7:0] mem [0:255];
    logic       mem_clr;
    logic [7:0] ra, wa;
    logic       rd_byte, rd_half, wr_byte, wr_half;
    assign ra      = mem_readAddr[7:0];
    assign wa      = mem_writeAddr[7:0];
    assign rd_byte = mem_addr_byte & ~mem_addr_half;
    assign rd_half = mem_addr_half & ~mem_addr_byte;
    assign wr_byte = rd_byte;
    assign wr_half = rd_half;

    always_comb begin
        mem_readData = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
        if (rd_byte)
            mem_readData = mem_zero_extend ? {24'd0, mem[ra]} : {{24{mem[ra][7]}}, mem[ra]};
        else if (rd_half)
            mem_readData = mem_zero_extend ? {16'd0, mem[ra + 8'd1], mem[ra]}
                                           : {{16{mem[ra + 8'd1][7]}}, mem[ra + 8'd1], mem[ra]};
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
        end else if (mem_writeEn) begin
            mem[wa] <= mem_writeData[7:0];
            if (!wr_byte) mem[wa + 8'd1] <= mem_writeData[15:8];
            if (!wr_byte && !wr_half) begin
                mem[wa + 8'd2] <= mem_writeData[23:16];
                mem[wa + 8'd3] <= mem_writeData[31:24];
            end
        end
    end

    typedef struct {
        logic r0; logic w0; logic [31:0] a0; logic [31:0] d0; logic [1:0] sz0; logic z0;
        logic r1; logic w1; logic [31:0] a1; logic [31:0] d1; logic [1:0] sz1; logic z1; logic l1;
        logic eg0; logic eg1; logic ewe;
        logic ev0; logic ev1; logic [31:0] erd0; logic [31:0] erd1; logic ee0; logic ee1;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [0:NV-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0; {byte0, half0} = v.sz0; zext0 = v.z0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1; {byte1, half1} = v.sz1; zext1 = v.z1;
        lock1 = v.l1;
    endtask

    task automatic step(input string nm, input logic eg0, input logic eg1);
        @(negedge clk);
        chk({nm, " gnt0"}, 32'(gnt0), 32'(eg0));
        chk({nm, " gnt1"}, 32'(gnt1), 32'(eg1));
        @(posedge clk); #1;
        chk({nm, " rvalid0"}, 32'(rvalid0), 32'(eg0));
        chk({nm, " rvalid1"}, 32'(rvalid1), 32'(eg1));
        if (eg0) chk({nm, " rdata0"}, rdata0, 32'hDEADBEEF);
        if (eg1) chk({nm, " rdata1"}, rdata1, 32'h000000A5);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            r0   w0   a0         d0            sz0 z0    r1   w1   a1         d1            sz1 z1    l1    eg0  eg1  ewe   ev0  ev1  erd0          erd1          ee0  ee1
        vecs[0]  = '{1'b1,1'b1,32'h8,     32'hDEADBEEF, W, 1'b0, 1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b0, 1'b1,1'b0,1'b1, 1'b1,1'b0,32'h0,        32'h0,        1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,32'h8,     32'h0,        W, 1'b0, 1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'hDEADBEEF, 32'h0,        1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b1,1'b0,32'h8,     32'h0,        W, 1'b0, 1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'hDEADBEEF, 32'hDEADBEEF, 1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,32'hB,     32'h0,        B, 1'b0, 1'b1,1'b0,32'h8,     32'h0,        B, 1'b1, 1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'hFFFFFFDE, 32'hDEADBEEF, 1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,32'hB,     32'h0,        B, 1'b0, 1'b1,1'b0,32'h8,     32'h0,        B, 1'b1, 1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'hFFFFFFDE, 32'h000000EF, 1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,32'hB,     32'h0,        B, 1'b0, 1'b1,1'b0,32'h8,     32'h0,        B, 1'b1, 1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'hFFFFFFDE, 32'h000000EF, 1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,32'hB,     32'h0,        B, 1'b0, 1'b1,1'b0,32'h8,     32'h0,        B, 1'b1, 1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'hFFFFFFDE, 32'h000000EF, 1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b1,1'b1,32'h11,    32'h5A,       B, 1'b0, 1'b0, 1'b0,1'b1,1'b1, 1'b0,1'b1,32'hFFFFFFDE, 32'h0,        1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b1,1'b0,32'h11,    32'h0,        B, 1'b0, 1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'hFFFFFFDE, 32'h0000005A, 1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b1,1'b1,32'h11,    32'h123456A5, B, 1'b0, 1'b0, 1'b0,1'b1,1'b1, 1'b0,1'b1,32'hFFFFFFDE, 32'h0,        1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b1,1'b0,32'h11,    32'h0,        B, 1'b0, 1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'hFFFFFFDE, 32'hFFFFFFA5, 1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b1,1'b0,32'h11,    32'h0,        B, 1'b1, 1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'hFFFFFFDE, 32'h000000A5, 1'b0,1'b0};
        vecs[12] = '{1'b1,1'b1,32'h12,    32'h00001234, H, 1'b0, 1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b0, 1'b1,1'b0,1'b1, 1'b1,1'b0,32'h0,        32'h000000A5, 1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,32'h12,    32'h0,        H, 1'b0, 1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'h00001234, 32'h000000A5, 1'b0,1'b0};
        vecs[14] = '{1'b1,1'b1,32'h3,     32'hFFFFFFFF, H, 1'b0, 1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'h0,        32'h000000A5, 1'b1,1'b0};
        vecs[15] = '{1'b1,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'h0,        32'h000000A5, 1'b0,1'b0};
        vecs[16] = '{1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b1,1'b0,32'h6,     32'h0,        W, 1'b0, 1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'h0,        32'h0,        1'b0,1'b1};
        vecs[17] = '{1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b1,1'b0,32'h8,     32'h0,        BH,1'b0, 1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'h0,        32'hDEADBEEF, 1'b0,1'b0};
        vecs[18] = '{1'b1,1'b0,32'h12,    32'h0,        H, 1'b1, 1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'h00001234, 32'hDEADBEEF, 1'b0,1'b0};
        vecs[19] = '{1'b1,1'b0,32'hA,     32'h0,        W, 1'b0, 1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b0, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'h0,        32'hDEADBEEF, 1'b1,1'b0};
        vecs[20] = '{1'b0,1'b0,32'h0,     32'h0,        W, 1'b0, 1'b1,1'b1,32'h2,     32'hFFFFFFFF, W, 1'b0, 1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'h0,        32'h0,        1'b0,1'b1};

        // Reset with both ports requesting: no grant, no write, cleared responses.
        rst_n = 1'b1; mem_clr = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h0; byte0 = 1'b0; half0 = 1'b0; zext0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0; wdata1 = 32'h0; byte1 = 1'b0; half1 = 1'b0; zext1 = 1'b0;
        lock1 = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset gnt0", 32'(gnt0), 32'd0);
        chk("reset gnt1", 32'(gnt1), 32'd0);
        chk("reset mem_writeEn", 32'(mem_writeEn), 32'd0);
        chk("reset rvalid0", 32'(rvalid0), 32'd0);
        chk("reset rvalid1", 32'(rvalid1), 32'd0);
        chk("reset rdata0", rdata0, 32'h0);
        chk("reset rdata1", rdata1, 32'h0);
        chk("reset err0", 32'(err0), 32'd0);
        chk("reset err1", 32'(err1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_clr = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d gnt0", i), 32'(gnt0), 32'(vecs[i].eg0));
            chk($sformatf("v%0d gnt1", i), 32'(gnt1), 32'(vecs[i].eg1));
            chk($sformatf("v%0d mem_writeEn", i), 32'(mem_writeEn), 32'(vecs[i].ewe));
            chk($sformatf("v%0d mem_readAddr", i), mem_readAddr,
                vecs[i].eg0 ? vecs[i].a0 : (vecs[i].eg1 ? vecs[i].a1 : 32'h0));
            @(posedge clk); #1;
            chk($sformatf("v%0d rvalid0", i), 32'(rvalid0), 32'(vecs[i].ev0));
            chk($sformatf("v%0d rvalid1", i), 32'(rvalid1), 32'(vecs[i].ev1));
            chk($sformatf("v%0d rdata0", i), rdata0, vecs[i].erd0);
            chk($sformatf("v%0d rdata1", i), rdata1, vecs[i].erd1);
            chk($sformatf("v%0d err0", i), 32'(err0), 32'(vecs[i].ee0));
            chk($sformatf("v%0d err1", i), 32'(err1), 32'(vecs[i].ee1));
        end

        // Lock sequence (LOCK_MAX = 4): tie to port 0, four locked port-1 grants, cooldown, relock.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8; byte0 = 1'b0; half0 = 1'b0; zext0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h11; byte1 = 1'b1; half1 = 1'b0; zext1 = 1'b1;
        lock1 = 1'b1;
        step("lock tie", 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step($sformatf("locked%0d", k), 1'b0, 1'b1);
        step("cooldown", 1'b1, 1'b0);
        step("relock", 1'b0, 1'b1);
        req1 = 1'b0; lock1 = 1'b0;
        step("lock drop", 1'b1, 1'b0);
        req0 = 1'b0; req1 = 1'b1;
        step("cooldown block", 1'b0, 1'b0);
        step("unlocked", 1'b0, 1'b1);

        // Reset hitting between a grant and its response edge.
        req0 = 1'b1; req1 = 1'b0;
        @(negedge clk);
        chk("pre-reset gnt0", 32'(gnt0), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("in-reset gnt0", 32'(gnt0), 32'd0);
        @(posedge clk); #1;
        chk("mid-reset rvalid0", 32'(rvalid0), 32'd0);
        chk("mid-reset rdata0", rdata0, 32'h0);
        chk("mid-reset rdata1", rdata1, 32'h0);
        req1 = 1'b1;
        @(posedge clk); #1;
        chk("held-reset rvalid1", 32'(rvalid1), 32'd0);
        rst_n = 1'b1;
        step("post-reset tie", 1'b1, 1'b0);
        step("post-reset rr", 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store unit, port 1 is the debug/DMA loader.
- Performs round-robin arbitration and checks alignment before driving the memory's address, data, size and extend controls.
- Registers read data back to the winning requester, with a bounded bus-lock feature for port 1.
- Sits between the core and debug logic on one side and the data memory on the other.

Parameters:
- BIT_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.
- LOCK_MAX, 16, maximum consecutive grants port 1 may hold while asserting lock; range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request; held high until the matching gnt.
- we0, we1  in  1  1 = store, 0 = load.
- addr0, addr1  in  ADDR_WIDTH  byte address.
- wdata0, wdata1  in  BIT_WIDTH  store data.
- byte0, half0, byte1, half1  in  1  access size; both low = word; both high is illegal and treated as word.
- zext0, zext1  in  1  zero-extend loads.
- lock1  in  1  port 1 requests to keep ownership.
- gnt0, gnt1  out  1  combinational grant this cycle.
- rvalid0, rvalid1  out  1  response valid, registered.
- rdata0, rdata1  out  BIT_WIDTH  load data, registered.
- err0, err1  out  1  misaligned-access flag, valid with rvalid.
- mem_readAddr, mem_writeAddr  out  ADDR_WIDTH  to memory.
- mem_writeData  out  BIT_WIDTH  to memory.
- mem_writeEn, mem_addr_byte, mem_addr_half, mem_zero_extend  out  1  to memory.
- mem_readData  in  BIT_WIDTH  combinational read data from memory.

Behaviour:
- Reset: all gnt, rvalid and err outputs = 0; rdata0/1 = 0; last_owner = 1, so port 0 wins the first tie; lock_cnt = 0; locked = 0; mem_writeEn = 0.
- Grant (combinational):
  - Only one requester: that requester is granted.
  - Both requesting: the port other than last_owner is granted.
  - locked = 1 and req1 = 1: port 1 is granted regardless of req0.
  - At most one gnt is high per cycle.
- Memory drive:
  - The granted port's addr drives both mem_readAddr and mem_writeAddr.
  - Size and extend bits pass through from the granted port.
  - mem_writeEn = granted & we & ~misaligned.
  - With no grant, addresses hold 0 and mem_writeEn = 0.
- Misaligned access is defined as any of:
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0.
- Misaligned handling: no write is performed; the response carries err = 1 and rdata = 0.
- Response, registered one cycle after the grant:
  - At the next rising edge, rvalidN = 1 for exactly one cycle.
  - rdataN = mem_readData sampled that edge for loads; 0 for stores.
  - errN is as computed above.
  - A port not granted has rvalid = 0 the following cycle; its rdata holds its last value.
- Throughput: one access per cycle. A requester may issue its next request in the cycle after its gnt; responses come back in order.
- Store visibility: a store to address A granted in cycle n is visible to a load of A granted in cycle n+1 or later. A same-cycle read of another address by the same grant is not possible.
- Lock state machine:
  - UNLOCKED -> LOCKED when port 1 is granted with lock1 = 1; lock_cnt = 1.
  - In LOCKED, each port-1 grant increments lock_cnt.
  - LOCKED -> COOLDOWN when any of: lock1 = 0, req1 = 0, or lock_cnt reaches LOCK_MAX after that grant.
  - COOLDOWN lasts exactly one cycle. Port 1 cannot be granted during it; port 0 is granted if it requests. Then the FSM returns to UNLOCKED.
  - A locked access is still counted as a port-1 grant for last_owner.
- Reset mid-operation: pending responses are discarded; no rvalid follows reset. The memory contents are not owned by this block.

Test Plan:
- Single load, port 0: addr0 = 0x8, word, memory holds 0xDEADBEEF at word 2 -> gnt0 in same cycle; next cycle rvalid0 = 1, rdata0 = 0xDEADBEEF, err0 = 0.
- Both requesting continuously, no lock, for 4 cycles -> grants alternate 0, 1, 0, 1; each rvalid follows its grant by one cycle.
- Store then load, port 1: store byte 0x5A to 0x11, then load signed byte from 0x11 -> rdata1 = 0x0000005A. Then store 0xA5 and load with zext1 = 0 -> rdata1 = 0xFFFFFFA5.
- Misaligned accesses: half store to 0x3 -> mem_writeEn stays 0, err = 1, memory unchanged; word load from 0x6 -> err = 1, rdata = 0.
- Lock with LOCK_MAX = 4: req1 and lock1 held, req0 held -> port 1 granted for 4 cycles, then a cooldown cycle grants port 0, then round-robin resumes with port 1.
- Reset mid-operation: assert rst_n low in the cycle after a grant -> rvalid stays 0 and rdata resets to 0; after release, the first tie is granted to port 0.
